// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ENTRY_W = 2 * XLEN;

  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous instruction buffer holding {pc, inst} pairs for decode.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             push,
  input  logic [ENTRY_W-1:0]               push_data,
  input  logic                             pop,
  output logic [ENTRY_W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               empty;
  logic               full;
  logic               do_push;
  logic               do_pop;

  always_comb begin
    empty   = (count == '0);
    full    = (count == CW'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_comb begin
    head = mem[rd_ptr];
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, runs the one-outstanding imem
// handshake and feeds decode through a small buffer.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  state_e         state;
  state_e         state_nxt;
  logic [31:0]    fetch_pc;
  logic [31:0]    fetch_pc_nxt;

  logic           outstanding;
  logic           credit;
  logic           gnt_ok;
  logic           push;
  logic           pop;
  logic           flush;
  fetch_entry_t   push_entry;
  fetch_entry_t   head_entry;
  logic [ENTRY_W-1:0] head_raw;
  logic [CW-1:0]  count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

  // Next-state, credit check and fetch PC update; redirect overrides everything.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    push         = 1'b0;
    flush        = 1'b0;
    outstanding  = (state != S_REQ);
    credit       = (32'(count) + 32'(outstanding)) < DEPTH;
    imem_req     = !rst && (state == S_REQ) && credit;
    gnt_ok       = imem_req && imem_gnt;

    case (state)
      S_REQ: begin
        if (gnt_ok) begin
          state_nxt    = redirect ? S_DROP : S_WAIT;
          fetch_pc_nxt = fetch_pc + 32'd4;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          state_nxt = S_DROP;
        end else if (imem_rvalid) begin
          push      = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rvalid && !redirect) begin
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase

    if (redirect) begin
      flush        = 1'b1;
      fetch_pc_nxt = word_align(redirect_pc);
    end
  end

  // In S_WAIT fetch_pc has already advanced past the outstanding address.
  always_comb begin
    push_entry.pc   = fetch_pc - 32'd4;
    push_entry.inst = imem_rdata;
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_raw),
    .count     (count)
  );

  always_comb begin
    head_entry  = fetch_entry_t'(head_raw);
    imem_addr   = rst ? RESET_PC : fetch_pc;
    id_valid    = !rst && (count != '0);
    pop         = id_valid && id_ready;
    id_inst     = id_valid ? head_entry.inst : NOP_INST;
    id_pc       = id_valid ? head_entry.pc : 32'd0;
    id_pc_plus4 = id_valid ? (head_entry.pc + 32'd4) : 32'd0;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a queue-based transaction model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (RPC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_inst     (id_inst),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: next fetch address, one in-flight request, delivery queue.
  logic [31:0] m_pc = RPC;
  logic [31:0] m_req_addr = 32'd0;
  bit          m_out = 1'b0;
  bit          m_drop = 1'b0;
  logic [63:0] m_q[$];
  bit          mem_pend = 1'b0;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_inst, s_pc, s_p4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare all outputs to the model, advance the model.
  task automatic cyc(input bit r, input bit g, input bit rv, input logic [31:0] rd,
                     input bit redir, input logic [31:0] rpc, input bit rdy);
    bit          e_req, e_valid, granted, pop;
    logic [31:0] e_addr, e_inst, e_pc, e_p4;
    @(negedge clk);
    rst = r; imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    redirect = redir; redirect_pc = rpc; id_ready = rdy;
    #1;
    e_req   = !r && !m_out && (m_q.size() < DEPTH);
    e_addr  = r ? RPC : m_pc;
    e_valid = !r && (m_q.size() != 0);
    e_inst  = NOP_INST;
    e_pc    = 32'd0;
    e_p4    = 32'd0;
    if (e_valid) begin
      e_inst = m_q[0][31:0];
      e_pc   = m_q[0][63:32];
      e_p4   = e_pc + 32'd4;
    end
    s_req = imem_req; s_addr = imem_addr; s_valid = id_valid;
    s_inst = id_inst; s_pc = id_pc; s_p4 = id_pc_plus4;
    check("imem_req", 32'(s_req), 32'(e_req));
    check("imem_addr", s_addr, e_addr);
    check("id_valid", 32'(s_valid), 32'(e_valid));
    check("id_inst", s_inst, e_inst);
    check("id_pc", s_pc, e_pc);
    check("id_pc_plus4", s_p4, e_p4);
    if (r) begin
      m_q.delete(); m_pc = RPC; m_out = 1'b0; m_drop = 1'b0; mem_pend = 1'b0;
    end else begin
      granted  = e_req && g;
      pop      = e_valid && rdy;
      mem_pend = (mem_pend && !rv) || granted;
      if (redir) begin
        m_q.delete();
        m_pc = rpc & 32'hFFFF_FFFC;
        if (granted || m_out) begin
          m_out = 1'b1; m_drop = 1'b1;
        end
      end else begin
        if (pop) void'(m_q.pop_front());
        if (m_out && rv) begin
          if (!m_drop) m_q.push_back({m_req_addr, rd});
          m_out = 1'b0; m_drop = 1'b0;
        end
        if (granted) begin
          m_req_addr = m_pc; m_pc = m_pc + 32'd4; m_out = 1'b1; m_drop = 1'b0;
        end
      end
    end
    @(posedge clk);
  endtask

  // Zero-wait memory: always grant, answer one cycle later.
  task automatic acyc(input bit rdy);
    cyc(1'b0, 1'b1, mem_pend, $urandom, 1'b0, 32'd0, rdy);
  endtask

  initial begin
    bit ok;
    bit r, rv, redir;

    // Reset and first fetch
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("rst_req", 32'(s_req), 32'd0);
    check("rst_addr", s_addr, 32'h100);
    check("rst_valid", 32'(s_valid), 32'd0);
    check("rst_inst", s_inst, 32'h0000_0013);
    check("rst_pc", s_pc, 32'd0);
    check("rst_p4", s_p4, 32'd0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    check("first_req", 32'(s_req), 32'd1);
    check("first_addr", s_addr, 32'h100);
    cyc(0, 0, 1, 32'h0050_0093, 0, 0, 0);
    check("second_addr", s_addr, 32'h104);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("lat_valid", 32'(s_valid), 32'd1);
    check("lat_inst", s_inst, 32'h0050_0093);
    check("lat_pc", s_pc, 32'h100);
    check("lat_p4", s_p4, 32'h104);

    // Backpressure with DEPTH=2 starting at PC 0
    cyc(0, 0, 0, 0, 1, 32'h0, 0);
    repeat (10) acyc(1'b0);
    check("bp_req", 32'(s_req), 32'd0);
    check("bp_valid", 32'(s_valid), 32'd1);
    check("bp_head0", s_pc, 32'h0);
    acyc(1'b1);
    check("bp_pop0", s_pc, 32'h0);
    acyc(1'b1);
    check("bp_pop1", s_pc, 32'h4);
    check("bp_resume_req", 32'(s_req), 32'd1);
    check("bp_resume_addr", s_addr, 32'h8);

    // Redirect while waiting for a response
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_out && !m_drop) begin
        ok = 1'b1;
        break;
      end
      acyc(1'b1);
    end
    check("reach_wait", 32'(ok), 32'd1);
    cyc(0, 0, 0, 0, 1, 32'h200, 1);
    cyc(0, 0, 1, $urandom, 0, 0, 1);
    check("drop_req", 32'(s_req), 32'd0);
    check("drop_valid", 32'(s_valid), 32'd0);
    cyc(0, 1, 0, 0, 0, 0, 1);
    check("rw_req", 32'(s_req), 32'd1);
    check("rw_addr", s_addr, 32'h200);
    cyc(0, 0, 1, 32'h1234_5678, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("rw_pc", s_pc, 32'h200);
    check("rw_inst", s_inst, 32'h1234_5678);

    // Redirect coinciding with grant and pop
    cyc(0, 1, 0, 0, 1, 32'h3FE, 1);
    check("rgp_req", 32'(s_req), 32'd1);
    cyc(0, 0, 1, $urandom, 0, 0, 1);
    check("rgp_valid", 32'(s_valid), 32'd0);
    check("rgp_drop_req", 32'(s_req), 32'd0);
    cyc(0, 1, 0, 0, 0, 0, 1);
    check("rgp_addr", s_addr, 32'h3FC);
    cyc(0, 0, 1, 32'hCAFE_0013, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("rgp_pc", s_pc, 32'h3FC);
    check("rgp_p4", s_p4, 32'h400);

    // Address wrap-around
    cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    check("wrap_addr0", s_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 1, 32'h0000_0073, 0, 0, 0);
    check("wrap_addr1", s_addr, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("wrap_pc", s_pc, 32'hFFFF_FFFC);
    check("wrap_p4", s_p4, 32'h0);

    // Reset in the middle of a transaction, then a stale response
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("mrst_req", 32'(s_req), 32'd0);
    cyc(0, 0, 1, $urandom, 0, 0, 0);
    check("stale_valid", 32'(s_valid), 32'd0);
    check("stale_req", 32'(s_req), 32'd1);
    check("stale_addr", s_addr, RPC);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("stale_valid2", 32'(s_valid), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      r     = ($urandom_range(0, 199) == 0);
      rv    = mem_pend && ($urandom_range(0, 2) != 0);
      redir = !r && !rv && ($urandom_range(0, 15) == 0);
      cyc(r, 1'($urandom_range(0, 1)), rv, $urandom, redir, $urandom,
          1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
